// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and register-file geometry for the register dump controller.
package rf_dump_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 4;
   localparam int RF_DEPTH  = 16;

endpackage

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: on a halt rising edge, walks the register file read port and streams
// registers FIRST_REG..LAST_REG out over valid/ready, holding off core writes meanwhile.
module rf_dump_ctrl
   import rf_dump_pkg::*;
#(
   parameter int DATA_W    = RF_DATA_W,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = RF_DEPTH - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hlt,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_rd_sel,
   output logic              rf_hold,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q, dump_idx_q;
   logic [DATA_W-1:0] dump_data_q;
   logic              hlt_q, busy_q, hold_q, valid_q, done_q, last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= FIRST_A;
         hlt_q       <= 1'b0;
         busy_q      <= 1'b0;
         hold_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         last_q      <= 1'b0;
         dump_idx_q  <= '0;
         dump_data_q <= '0;
      end else begin
         hlt_q <= hlt;
         case (state_q)
            IDLE: if (hlt && !hlt_q) begin
               state_q <= FETCH;
               idx_q   <= FIRST_A;
               busy_q  <= 1'b1;
               hold_q  <= 1'b1;
            end
            FETCH: begin
               dump_data_q <= rf_rd_data;
               dump_idx_q  <= idx_q;
               last_q      <= (idx_q == LAST_A);
               valid_q     <= 1'b1;
               state_q     <= SEND;
            end
            SEND: if (dump_ready) begin
               valid_q <= 1'b0;
               // idx stops at LAST_REG so it can never wrap past the end of the file
               if (idx_q == LAST_A) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= FETCH;
               end
            end
            DONE: if (!hlt) begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               hold_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_rd_addr = busy_q ? idx_q : '0;
   assign rf_rd_sel  = busy_q;
   assign busy       = busy_q;
   assign rf_hold    = hold_q;
   assign dump_valid = valid_q;
   assign dump_idx   = dump_idx_q;
   assign dump_data  = dump_data_q;
   assign dump_last  = last_q;
   assign done       = done_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: checks the dump controller against a queue-based model of the dump,
// plus literal checks for timing, backpressure, reset abort and a single-register build.
module tb_rf_dump_ctrl;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] data;
   } beat_t;

   logic        clk = 1'b0, rst_n = 1'b1, hlt = 1'b0, dump_ready = 1'b1, hlt7 = 1'b0;
   logic [15:0] rf [16];
   logic [3:0]  rf_rd_addr, dump_idx, addr7, idx7;
   logic [15:0] dump_data, data7;
   logic        rf_rd_sel, rf_hold, dump_valid, dump_last, busy, done;
   logic        sel7, hold7, valid7, last7, busy7, done7;

   int vecs = 0, errs = 0, hs = 0, last_cnt = 0;
   logic [15:0] last_data;

   always #5 clk = ~clk;

   rf_dump_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .hlt(hlt),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf[rf_rd_addr]), .rf_rd_sel(rf_rd_sel),
      .rf_hold(rf_hold), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
      .busy(busy), .done(done)
   );

   rf_dump_ctrl #(.FIRST_REG(7), .LAST_REG(7)) u_one (
      .clk(clk), .rst_n(rst_n), .hlt(hlt7),
      .rf_rd_addr(addr7), .rf_rd_data(rf[addr7]), .rf_rd_sel(sel7),
      .rf_hold(hold7), .dump_valid(valid7), .dump_ready(1'b1),
      .dump_idx(idx7), .dump_data(data7), .dump_last(last7),
      .busy(busy7), .done(done7)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a dump is the ordered list of registers still to deliver; each needs one
   // fetch cycle before it is offered, and leaves the list on an accepted handshake.
   bit    m_dump, m_done, m_hq;
   int    m_gap;
   beat_t m_q[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_dump = 0; m_done = 0; m_hq = 0; m_gap = 0; m_q.delete();
      end else begin
         if (m_dump) begin
            if (m_gap > 0) m_gap = 0;
            else if (dump_ready) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) begin m_dump = 0; m_done = 1; end
               else m_gap = 1;
            end
         end else if (m_done) begin
            if (!hlt) m_done = 0;
         end else if (hlt && !m_hq) begin
            for (int i = 1; i <= 15; i++) m_q.push_back('{idx: 4'(i), data: rf[i]});
            m_dump = 1; m_gap = 1;
         end
         m_hq = hlt;
      end
   end

   always @(negedge clk) begin
      bit e_dump, e_done, e_v;
      e_dump = rst_n && m_dump;
      e_done = rst_n && m_done;
      e_v    = e_dump && m_gap == 0;
      chk("busy", busy, e_dump);
      chk("rd_sel", rf_rd_sel, e_dump);
      chk("hold", rf_hold, e_dump || e_done);
      chk("done", done, e_done);
      chk("valid", dump_valid, e_v);
      chk("rd_addr", rf_rd_addr, e_dump ? m_q[0].idx : 4'd0);
      if (e_v) begin
         chk("beat_idx", dump_idx, m_q[0].idx);
         chk("beat_data", dump_data, m_q[0].data);
         chk("beat_last", dump_last, m_q.size() == 1);
      end
      if (!rst_n) chk("rst_data", dump_data, 0);
      if (rst_n && dump_valid && dump_ready) begin
         hs++;
         if (dump_last) begin last_cnt++; last_data = dump_data; end
      end
   end

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic run_to_done(input int bound, input bit rnd, output int cyc);
      cyc = 0;
      while (!done && cyc < bound) begin
         if (rnd) dump_ready = 1'($urandom_range(0, 1));
         step; cyc++;
      end
      chk("reach_done", done, 1);
      dump_ready = 1'b1;
   endtask

   task automatic wait_beat(input logic [3:0] i);
      int n = 0;
      while (!(dump_valid && dump_idx == i) && n < 60) begin step; n++; end
      chk("reach_beat", {dump_valid, dump_idx}, {1'b1, i});
   endtask

   initial begin
      int c, h0;
      for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", busy, 0); chk("rst_valid", dump_valid, 0); chk("rst_done", done, 0);
      chk("rst_hold", rf_hold, 0); chk("rst_addr", rf_rd_addr, 0); chk("rst_idx", dump_idx, 0);
      step; step; rst_n = 1'b1; step;

      // full dump, ready high
      hlt = 1'b1; h0 = hs; step;
      chk("N_valid", dump_valid, 0); chk("N_hold", rf_hold, 1); chk("N_addr", rf_rd_addr, 1);
      step;
      chk("first_valid", dump_valid, 1); chk("first_idx", dump_idx, 1);
      chk("first_data", dump_data, 16'h1001); chk("first_last", dump_last, 0);
      run_to_done(100, 0, c);
      chk("done_cycles", c + 1, 30);
      chk("beats_full", hs - h0, 15);
      chk("last_once", last_cnt, 1); chk("last_data", last_data, 16'h100F);
      repeat (5) step;
      chk("hold_hi_done", done, 1); chk("hold_hi_busy", busy, 0);
      chk("no_restart", hs - h0, 15);
      hlt = 1'b0; step;
      chk("drop_done", done, 0); chk("drop_hold", rf_hold, 0);
      step;

      // backpressure at idx 5, also the repeated identical dump
      hlt = 1'b1; h0 = hs;
      wait_beat(4'd5);
      dump_ready = 1'b0;
      repeat (3) begin
         step;
         chk("bp_valid", dump_valid, 1); chk("bp_idx", dump_idx, 5); chk("bp_data", dump_data, 16'h1005);
      end
      dump_ready = 1'b1; step; step;
      chk("bp_next", {dump_valid, dump_idx}, {1'b1, 4'd6});
      run_to_done(100, 0, c);
      chk("beats_bp", hs - h0, 15);
      hlt = 1'b0; step; step;

      // hlt falls mid-dump
      hlt = 1'b1; h0 = hs;
      wait_beat(4'd3);
      hlt = 1'b0;
      run_to_done(100, 0, c);
      chk("beats_drop", hs - h0, 15);
      step;
      chk("done_pulse", done, 0); chk("drop_idle_hold", rf_hold, 0);
      step;

      // asynchronous reset during SEND at idx 8
      hlt = 1'b1;
      wait_beat(4'd8);
      #2 rst_n = 1'b0; hlt = 1'b0;
      #1;
      chk("ar_valid", dump_valid, 0); chk("ar_busy", busy, 0); chk("ar_hold", rf_hold, 0);
      chk("ar_sel", rf_rd_sel, 0); chk("ar_addr", rf_rd_addr, 0); chk("ar_idx", dump_idx, 0);
      chk("ar_data", dump_data, 0); chk("ar_last", dump_last, 0); chk("ar_done", done, 0);
      step; rst_n = 1'b1; step;
      hlt = 1'b1; h0 = hs; step; step;
      chk("restart_idx", {dump_valid, dump_idx}, {1'b1, 4'd1});
      chk("restart_data", dump_data, 16'h1001);
      run_to_done(100, 0, c);
      chk("beats_restart", hs - h0, 15);
      hlt = 1'b0; step; step;

      // random contents and random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
         hlt = 1'b1; h0 = hs;
         run_to_done(400, 1, c);
         chk("beats_rand", hs - h0, 15);
         repeat (int'($urandom_range(0, 3))) step;
         hlt = 1'b0; step; step;
      end

      // single-register build
      rf[7] = 16'hBEEF;
      hlt7 = 1'b1; step;
      chk("one_addr", addr7, 7); chk("one_sel", sel7, 1); chk("one_valid0", valid7, 0);
      step;
      chk("one_valid", valid7, 1); chk("one_idx", idx7, 7);
      chk("one_last", last7, 1); chk("one_data", data7, 16'hBEEF);
      step;
      chk("one_done", done7, 1); chk("one_valid_end", valid7, 0);
      chk("one_busy", busy7, 0); chk("one_hold", hold7, 1);
      hlt7 = 1'b0; step;
      chk("one_idle", done7, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
